mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: ld_req  in  1  load requester wants port; ld_addr  in  32  load address; ld_rob  in  6  load ROB tag.
REQ-004 SHALL have: st_req  in  1  store requester wants port; st_addr  in  32; st_data  in  32; st_rob  in  6.
REQ-005 SHALL have: ld_grant  out  1  and  st_grant  out  1  one-cycle pulse, request accepted, operands latched.
REQ-006 SHALL have: ld_done  out  1  pulse; ld_rdata  out  32  read data; ld_rob_out  out  6; st_done  out  1  pulse; st_rob_out  out  6.
REQ-007 SHALL have: mem_addr  out  32; mem_re  out  1; mem_we  out  1; mem_wdata  out  32; mem_rdata  in  32; mem_ready  in  1  access complete.
REQ-008 SHALL have: busy  out  1  high in any non-IDLE state.

Function
REQ-009 SHALL implement states IDLE, LOAD, STORE, held in a registered state variable.
REQ-010 In IDLE, on a rising edge with exactly one request high, SHALL enter that request's access state.
REQ-011 In IDLE with both requests high, SHALL grant the requester not served last (round-robin via 1-bit last_served), then update last_served.
REQ-012 On the granting edge SHALL latch addr/data/rob into internal registers and drive grant high for exactly the next cycle.
REQ-013 In LOAD SHALL drive mem_re=1, mem_we=0, mem_addr=latched address; in STORE mem_we=1, mem_re=0, mem_wdata=latched data; in IDLE mem_re=mem_we=0.
REQ-014 mem_ready SHALL be sampled only in LOAD/STORE; in IDLE it is ignored.
REQ-015 On the edge where mem_ready=1 in LOAD: SHALL register mem_rdata into ld_rdata, ld_rob_out=latched tag, pulse ld_done one cycle, return to IDLE.
REQ-016 On the edge where mem_ready=1 in STORE: SHALL set st_rob_out, pulse st_done one cycle, return to IDLE.
REQ-017 Minimum latency: req at cycle 0 -> grant/mem strobe in cycle 1 -> done in cycle 2; next grant no earlier than cycle 3.
REQ-018 Requests dropped or changed after grant SHALL NOT affect the access in flight.
REQ-019 ld_rdata and rob outputs SHALL hold their last value between done pulses.
REQ-020 ld_grant and st_grant SHALL never be high in the same cycle; likewise mem_re and mem_we.

Reset
REQ-021 On reset high, immediately and regardless of clock: state=IDLE, all grant/done/strobe outputs 0, busy 0, ld_rdata 0, rob outputs 0, last_served=store.
REQ-022 Reset asserted mid-access SHALL abandon the access with no done pulse; after release the first tie goes to load.

Configuration
REQ-023 Macro MEM_TIMEOUT_EN: when defined, an 8-bit counter SHALL clear on entering LOAD/STORE and increment each cycle waiting; on reaching 255 without mem_ready SHALL pulse output timeout_err (1 bit) for one cycle, return to IDLE, emit no done.
REQ-024 Without MEM_TIMEOUT_EN: no counter, no timeout_err port; access waits indefinitely for mem_ready.

Verification
REQ-025 ld_req only, ld_addr=0x100, ld_rob=5, mem_ready high in grant cycle, mem_rdata=0xDEADBEEF -> ld_grant cycle 1, ld_done cycle 2, ld_rdata=0xDEADBEEF, ld_rob_out=5.
REQ-026 ld_req and st_req both held from reset release -> grants alternate load, store, load; never both strobes together.
REQ-027 st_req, st_addr=0x40, st_data=0x12345678, mem_ready delayed 3 cycles -> mem_we held 4 cycles with mem_wdata=0x12345678, one st_done pulse.
REQ-028 Reset pulsed while in LOAD waiting for mem_ready -> outputs zero immediately, no ld_done, next tie grants load.
REQ-029 With MEM_TIMEOUT_EN, ld_req and mem_ready held low -> timeout_err pulse after 255 wait cycles, state IDLE, no ld_done.
REQ-030 mem_ready pulsed while IDLE with no requests -> no done, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (load/store) arbiter for a single memory port, round-robin on ties.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog and the timeout_err output.
module mem_port_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [5:0]  ld_rob,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [5:0]  st_rob,
   output logic        ld_grant,
   output logic        st_grant,
   output logic        ld_done,
   output logic [31:0] ld_rdata,
   output logic [5:0]  ld_rob_out,
   output logic        st_done,
   output logic [5:0]  st_rob_out,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        timeout_err
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

   state_t      state_reg, state_next;
   logic        last_served_reg, last_served_next;   // 1 = store was served last
   logic        load_go, store_go, ld_fin, st_fin, tmo;
   logic        pick_ld, pick_st;

   logic [31:0] addr_reg, data_reg;
   logic [5:0]  rob_reg;
   logic        ld_grant_reg, st_grant_reg, ld_done_reg, st_done_reg, timeout_reg;
   logic [31:0] ld_rdata_reg;
   logic [5:0]  ld_rob_out_reg, st_rob_out_reg;

   // On a tie, serve whichever side was not served most recently.
   assign pick_ld = ld_req && (!st_req || last_served_reg);
   assign pick_st = st_req && !pick_ld;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wait_cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         wait_cnt_reg <= 8'd0;
      else if (state_reg == IDLE)
         wait_cnt_reg <= 8'd0;
      else if (!mem_ready)
         wait_cnt_reg <= wait_cnt_reg + 8'd1;
   end

   assign tmo = (state_reg != IDLE) && !mem_ready && (wait_cnt_reg == 8'd254);
   assign timeout_err = timeout_reg;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         last_served_reg <= 1'b1;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      last_served_next = last_served_reg;
      load_go          = 1'b0;
      store_go         = 1'b0;
      ld_fin           = 1'b0;
      st_fin           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_ld) begin
               load_go          = 1'b1;
               last_served_next = 1'b0;
               state_next       = LOAD;
            end else if (pick_st) begin
               store_go         = 1'b1;
               last_served_next = 1'b1;
               state_next       = STORE;
            end
         end
         LOAD: begin
            if (mem_ready) begin
               ld_fin     = 1'b1;
               state_next = IDLE;
            end else if (tmo) begin
               state_next = IDLE;
            end
         end
         STORE: begin
            if (mem_ready) begin
               st_fin     = 1'b1;
               state_next = IDLE;
            end else if (tmo) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands are captured at grant so later request changes cannot disturb the access.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_reg <= 32'd0;
         data_reg <= 32'd0;
         rob_reg  <= 6'd0;
      end else if (load_go) begin
         addr_reg <= ld_addr;
         rob_reg  <= ld_rob;
      end else if (store_go) begin
         addr_reg <= st_addr;
         data_reg <= st_data;
         rob_reg  <= st_rob;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ld_grant_reg   <= 1'b0;
         st_grant_reg   <= 1'b0;
         ld_done_reg    <= 1'b0;
         st_done_reg    <= 1'b0;
         timeout_reg    <= 1'b0;
         ld_rdata_reg   <= 32'd0;
         ld_rob_out_reg <= 6'd0;
         st_rob_out_reg <= 6'd0;
      end else begin
         ld_grant_reg <= load_go;
         st_grant_reg <= store_go;
         ld_done_reg  <= ld_fin;
         st_done_reg  <= st_fin;
         timeout_reg  <= tmo;
         if (ld_fin) begin
            ld_rdata_reg   <= mem_rdata;
            ld_rob_out_reg <= rob_reg;
         end
         if (st_fin)
            st_rob_out_reg <= rob_reg;
      end
   end

   assign ld_grant   = ld_grant_reg;
   assign st_grant   = st_grant_reg;
   assign ld_done    = ld_done_reg;
   assign st_done    = st_done_reg;
   assign ld_rdata   = ld_rdata_reg;
   assign ld_rob_out = ld_rob_out_reg;
   assign st_rob_out = st_rob_out_reg;

   assign mem_addr  = addr_reg;
   assign mem_wdata = data_reg;
   assign mem_re    = (state_reg == LOAD);
   assign mem_we    = (state_reg == STORE);
   assign busy      = (state_reg != IDLE);

endmodule
